// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, widths and constants for the alu_core datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 32;

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t ALUOP_NOP   = 5'd0;
  localparam alu_op_t ALUOP_ADD   = 5'd1;
  localparam alu_op_t ALUOP_SUB   = 5'd2;
  localparam alu_op_t ALUOP_SLT   = 5'd3;
  localparam alu_op_t ALUOP_SLTU  = 5'd4;
  localparam alu_op_t ALUOP_AND   = 5'd5;
  localparam alu_op_t ALUOP_OR    = 5'd6;
  localparam alu_op_t ALUOP_NOR   = 5'd7;
  localparam alu_op_t ALUOP_LUI   = 5'd8;
  localparam alu_op_t ALUOP_SLL   = 5'd9;
  localparam alu_op_t ALUOP_SRL   = 5'd10;
  localparam alu_op_t ALUOP_SRA   = 5'd11;
  localparam alu_op_t ALUOP_MULT  = 5'd12;
  localparam alu_op_t ALUOP_MULTU = 5'd13;
  localparam alu_op_t ALUOP_DIV   = 5'd14;
  localparam alu_op_t ALUOP_DIVU  = 5'd15;

  localparam logic [ALU_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/alu_divider.sv
// ============================================================================
// Module      : alu_divider
// Description : Combinational 32-bit signed/unsigned divider (quotient, remainder).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_divider
  import alu_pkg::*;
(
  input  logic             i_signed,
  input  logic [ALU_W-1:0] i_dividend,
  input  logic [ALU_W-1:0] i_divisor,
  output logic [ALU_W-1:0] o_quot,
  output logic [ALU_W-1:0] o_rem
);

  logic             w_a_neg;
  logic             w_b_neg;
  logic [ALU_W-1:0] w_a_mag;
  logic [ALU_W-1:0] w_b_mag;
  logic [ALU_W-1:0] w_b_safe;
  logic [ALU_W-1:0] w_q_mag;
  logic [ALU_W-1:0] w_r_mag;
  logic             w_by_zero;
  logic             w_sovf;

  // Divide magnitudes, then restore signs: truncation toward zero, remainder follows dividend.
  assign w_a_neg   = i_signed & i_dividend[ALU_W-1];
  assign w_b_neg   = i_signed & i_divisor[ALU_W-1];
  assign w_a_mag   = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_b_mag   = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
  assign w_by_zero = (i_divisor == '0);
  assign w_b_safe  = w_by_zero ? 32'd1 : w_b_mag;
  assign w_q_mag   = w_a_mag / w_b_safe;
  assign w_r_mag   = w_a_mag % w_b_safe;
  assign w_sovf    = i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);

  always_comb begin
    o_quot = '0;
    o_rem  = '0;
    if (w_by_zero) begin
      o_quot = DIV0_QUOT;
      o_rem  = i_dividend;
    end else if (w_sovf) begin
      o_quot = 32'h8000_0000;
      o_rem  = '0;
    end else begin
      o_quot = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
      o_rem  = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module      : alu_core
// Description : 32-bit MIPS-style ALU with 64-bit {HI,LO} result and sticky
//               divide-by-zero flag. Optional ovf_o port under ALU_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         ALU_control_i,
  input  logic [ALU_W-1:0]   src0_i,
  input  logic [ALU_W-1:0]   src1_i,
  output logic [2*ALU_W-1:0] ALU_result_o,
  output logic               Zero_o,
  output logic               div0_o
`ifdef ALU_OVF_EN
  ,
  output logic               ovf_o
`endif
);

  logic [ALU_W-1:0]          w_sum;
  logic [ALU_W-1:0]          w_diff;
  logic [4:0]                w_shamt;
  logic signed [2*ALU_W-1:0] w_a_sx;
  logic signed [2*ALU_W-1:0] w_b_sx;
  logic signed [2*ALU_W-1:0] w_prod_s;
  logic [2*ALU_W-1:0]        w_prod_u;
  logic                      w_is_div;
  logic                      w_div_signed;
  logic [ALU_W-1:0]          w_quot;
  logic [ALU_W-1:0]          w_rem;
  logic                      r_div0;

  assign w_sum    = src0_i + src1_i;
  assign w_diff   = src0_i - src1_i;
  assign w_shamt  = src0_i[4:0];
  assign w_a_sx   = {{ALU_W{src0_i[ALU_W-1]}}, src0_i};
  assign w_b_sx   = {{ALU_W{src1_i[ALU_W-1]}}, src1_i};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = {32'd0, src0_i} * {32'd0, src1_i};

  assign w_is_div     = (ALU_control_i == ALUOP_DIV) || (ALU_control_i == ALUOP_DIVU);
  assign w_div_signed = (ALU_control_i == ALUOP_DIV);

  alu_divider u_divider (
    .i_signed   (w_div_signed),
    .i_dividend (src0_i),
    .i_divisor  (src1_i),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_comb begin
    ALU_result_o = '0;
    case (ALU_control_i)
      ALUOP_ADD:   ALU_result_o[31:0] = w_sum;
      ALUOP_SUB:   ALU_result_o[31:0] = w_diff;
      ALUOP_SLT:   ALU_result_o[31:0] = {31'd0, ($signed(src0_i) < $signed(src1_i))};
      ALUOP_SLTU:  ALU_result_o[31:0] = {31'd0, (src0_i < src1_i)};
      ALUOP_AND:   ALU_result_o[31:0] = src0_i & src1_i;
      ALUOP_OR:    ALU_result_o[31:0] = src0_i | src1_i;
      ALUOP_NOR:   ALU_result_o[31:0] = ~(src0_i | src1_i);
      ALUOP_LUI:   ALU_result_o[31:0] = {src1_i[15:0], 16'h0000};
      ALUOP_SLL:   ALU_result_o[31:0] = src1_i << w_shamt;
      ALUOP_SRL:   ALU_result_o[31:0] = src1_i >> w_shamt;
      ALUOP_SRA:   ALU_result_o[31:0] = $signed(src1_i) >>> w_shamt;
      ALUOP_MULT:  ALU_result_o       = w_prod_s;
      ALUOP_MULTU: ALU_result_o       = w_prod_u;
      ALUOP_DIV,
      ALUOP_DIVU:  ALU_result_o       = {w_rem, w_quot};
      default:     ALU_result_o       = '0;
    endcase
  end

  assign Zero_o = (ALU_result_o[31:0] == '0);

  // Sticky until reset; reset wins over a simultaneous divide-by-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div0 <= 1'b0;
    end else if (w_is_div && (src1_i == '0)) begin
      r_div0 <= 1'b1;
    end
  end

  assign div0_o = r_div0;

`ifdef ALU_OVF_EN
  always_comb begin
    ovf_o = 1'b0;
    if (ALU_control_i == ALUOP_ADD) begin
      ovf_o = (src0_i[31] == src1_i[31]) && (w_sum[31] != src0_i[31]);
    end else if (ALU_control_i == ALUOP_SUB) begin
      ovf_o = (src0_i[31] != src1_i[31]) && (w_diff[31] != src0_i[31]);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// Module      : tb_alu_core
// Description : Directed self-checking bench for alu_core with an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_core;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] res;
  logic        zero;
  logic        div0;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  exp_t        sb_q[$];
  int          n_tests;
  int          n_fail;

  alu_core dut (
    .clk           (clk),
    .rst           (rst),
    .ALU_control_i (op),
    .src0_i        (a),
    .src1_i        (b),
    .ALU_result_o  (res),
    .Zero_o        (zero),
    .div0_o        (div0)
`ifdef ALU_OVF_EN
    ,
    .ovf_o         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, check just after the following rising edge.
  task automatic apply(input string tag, input logic [4:0] t_op, input logic [31:0] t_a,
                       input logic [31:0] t_b, input logic [63:0] t_exp, input logic t_ovf);
    exp_t e;
    exp_t got;
    @(negedge clk);
    op = t_op;
    a  = t_a;
    b  = t_b;
    e.tag  = tag;
    e.res  = t_exp;
    e.zero = (t_exp[31:0] == 32'd0);
    e.ovf  = t_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
    end
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      assert (res === got.res) else begin
        n_fail++;
        $error("FAIL %s.result: got %h expected %h", got.tag, res, got.res);
      end
      n_tests++;
      assert (zero === got.zero) else begin
        n_fail++;
        $error("FAIL %s.zero: got %b expected %b", got.tag, zero, got.zero);
      end
`ifdef ALU_OVF_EN
      n_tests++;
      assert (ovf === got.ovf) else begin
        n_fail++;
        $error("FAIL %s.ovf: got %b expected %b", got.tag, ovf, got.ovf);
      end
`endif
    end
  endtask

  task automatic check_div0(input string tag, input logic t_exp);
    n_tests++;
    assert (div0 === t_exp) else begin
      n_fail++;
      $error("FAIL %s: div0 got %b expected %b", tag, div0, t_exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    op  = ALUOP_NOP;
    a   = 32'd0;
    b   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_div0("reset_div0", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply("nop",        ALUOP_NOP,   32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1'b0);
    apply("sub_eq",     ALUOP_SUB,   32'd5, 32'd5, 64'h0, 1'b0);
    apply("sub_neg",    ALUOP_SUB,   32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE, 1'b0);
    apply("add_wrap",   ALUOP_ADD,   32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000, 1'b1);
    apply("sub_ovf",    ALUOP_SUB,   32'h8000_0000, 32'd1, 64'h0000_0000_7FFF_FFFF, 1'b1);
    apply("add_noovf",  ALUOP_ADD,   32'hFFFF_FFFF, 32'd1, 64'h0, 1'b0);
    apply("slt",        ALUOP_SLT,   32'hFFFF_FFFF, 32'd1, 64'h1, 1'b0);
    apply("sltu",       ALUOP_SLTU,  32'hFFFF_FFFF, 32'd1, 64'h0, 1'b0);
    apply("and",        ALUOP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 1'b0);
    apply("or",         ALUOP_OR,    32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_FFF0_FFF0, 1'b0);
    apply("nor",        ALUOP_NOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_000F_000F, 1'b0);
    apply("lui",        ALUOP_LUI,   32'hDEAD_BEEF, 32'hABCD_1234, 64'h0000_0000_1234_0000, 1'b0);
    apply("sra",        ALUOP_SRA,   32'd4, 32'h8000_0000, 64'h0000_0000_F800_0000, 1'b0);
    apply("srl",        ALUOP_SRL,   32'd4, 32'h8000_0000, 64'h0000_0000_0800_0000, 1'b0);
    apply("sll_amt36",  ALUOP_SLL,   32'd36, 32'd1, 64'h0000_0000_0000_0010, 1'b0);
    apply("mult",       ALUOP_MULT,  32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    apply("multu",      ALUOP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b0);
    apply("mult_min",   ALUOP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    apply("div_neg",    ALUOP_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    apply("div_negb",   ALUOP_DIV,   32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    apply("divu",       ALUOP_DIVU,  32'd7, 32'd2, 64'h0000_0001_0000_0003, 1'b0);
    apply("div_sovf",   ALUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    apply("op_20",      5'd20,       32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 1'b0);
    check_div0("div0_clear", 1'b0);

    apply("divu_zero",  ALUOP_DIVU,  32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b0);
    check_div0("div0_set", 1'b1);
    apply("after_add",  ALUOP_ADD,   32'd2, 32'd3, 64'h5, 1'b0);
    check_div0("div0_sticky", 1'b1);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_div0("div0_rst", 1'b0);

    // Reset and divide-by-zero presented together: reset wins.
    apply("div_zero_rst", ALUOP_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    check_div0("div0_rst_prio", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply("div_zero",   ALUOP_DIV,   32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
    check_div0("div0_set_div", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
